// File: rtl/pwm_capture.sv
// PWM input capture: period and high time of pwm_in in 2^prescale ticks.
// Define PWM_CAPTURE_FILT_EN to add a 3-sample stability filter on the input.
module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_in,
    input  logic               en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale,
    output logic [CNT_W-1:0]   period_val,
    output logic [CNT_W-1:0]   high_val,
    output logic               valid,
    output logic               ovf,
    output logic               sig_lost
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t             state, state_nx;
    logic               s1, s2, lvl, lvl_d;
    logic               rise_ev, fall_ev;
    logic [CNT_W-1:0]   cnt, cnt_inc, presc_cnt, presc_mask, hi_shadow;
    logic [PRESC_W-1:0] ps_clamp;
    logic               tick, meas_bad;
    logic               running, restart, capture, bad_close;

`ifdef PWM_CAPTURE_FILT_EN
    logic h1, h2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 <= 1'b0;
            h2 <= 1'b0;
        end else begin
            h1 <= s2;
            h2 <= h1;
        end
    end

    // level moves only after three equal synchronized samples
    assign lvl_d = (s2 == h1 && h1 == h2) ? s2 : lvl;
`else
    assign lvl_d = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            lvl     <= 1'b0;
            rise_ev <= 1'b0;
            fall_ev <= 1'b0;
        end else begin
            s1      <= pwm_in;
            s2      <= s1;
            lvl     <= lvl_d;
            rise_ev <= lvl_d & ~lvl;
            fall_ev <= ~lvl_d & lvl;
        end
    end

    assign ps_clamp   = (prescale > PRESC_W'(CNT_W - 1)) ?
                        PRESC_W'(CNT_W - 1) : prescale;
    assign presc_mask = (CNT_W'(1) << ps_clamp) - CNT_W'(1);
    assign tick       = (presc_cnt == presc_mask);
    assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(tick);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = en ? ARM : IDLE;
        end else if (!en) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = ARM;
                ARM:  if (rise_ev) state_nx = HIGH;
                HIGH: if (fall_ev) state_nx = LOW;
                LOW:  if (rise_ev) state_nx = HIGH;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        running   = ~clear & en & (state == HIGH || state == LOW);
        restart   = ~clear & en & rise_ev & (state == ARM || state == LOW);
        capture   = restart & (state == LOW) & ~meas_bad;
        bad_close = restart & (state == LOW) & meas_bad;
        sig_lost  = (&cnt) & (state == HIGH || state == LOW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_val <= '0;
            high_val   <= '0;
            valid      <= 1'b0;
            ovf        <= 1'b0;
            cnt        <= '0;
            presc_cnt  <= '0;
            hi_shadow  <= '0;
            meas_bad   <= 1'b0;
        end else begin
            valid <= capture;
            if (clear) begin
                period_val <= '0;
                high_val   <= '0;
                ovf        <= 1'b0;
            end else if (capture) begin
                period_val <= cnt_inc;
                high_val   <= hi_shadow;
            end else if (bad_close) begin
                ovf <= 1'b1;
            end

            if (restart || !running) begin
                cnt       <= '0;
                presc_cnt <= '0;
                meas_bad  <= 1'b0;
            end else begin
                cnt       <= cnt_inc;
                presc_cnt <= tick ? '0 : presc_cnt + CNT_W'(1);
                if (&cnt_inc) meas_bad <= 1'b1;
                if (state == HIGH && fall_ev) hi_shadow <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected results,
// a negedge monitor pops and compares on every valid pulse.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;
`ifdef PWM_CAPTURE_FILT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pwm_in = 1'b0;
    logic               en = 1'b0;
    logic               clear = 1'b0;
    logic [PRESC_W-1:0] prescale = '0;
    logic [CNT_W-1:0]   period_val, high_val;
    logic               valid, ovf, sig_lost;

    pwm_capture #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .en(en), .clear(clear),
        .prescale(prescale), .period_val(period_val), .high_val(high_val),
        .valid(valid), .ovf(ovf), .sig_lost(sig_lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   have_start = 0;
    int   prev_h = 0, prev_p = 0, ps = 0;
    bit   exp_ovf = 0;
    int   exp_pv = 0, exp_hv = 0;
    bit   valid_prev = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit lv, input int n);
        pwm_in = lv;
        step(n);
    endtask

    // A rise closes the previous pulse's period: results in whole ticks.
    task automatic model_rise(input int h, input int p);
        if (have_start) begin
            int tp, th;
            tp = prev_p >> ps;
            th = prev_h >> ps;
            if (tp >= 65535) begin
                exp_ovf = 1;
            end else begin
                q.push_back('{p: tp, h: th});
                exp_pv = tp;
                exp_hv = th;
            end
        end
        have_start = 1;
        prev_h = h;
        prev_p = p;
    endtask

    task automatic pulse(input int h, input int l);
        model_rise(h, h + l);
        drive(1'b1, h);
        drive(1'b0, l);
    endtask

    task automatic do_clear();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            step(1);
            guard++;
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        have_start = 0;
        exp_ovf = 0;
        exp_pv = 0;
        exp_hv = 0;
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            exp_t e;
            if (valid_prev) chk("valid_width", 2, 1);
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got period %0d high %0d, required no valid",
                         period_val, high_val);
            end else begin
                e = q.pop_front();
                chk("period_val", int'(period_val), e.p);
                chk("high_val", int'(high_val), e.h);
            end
        end
        valid_prev <= valid;
    end

    initial begin
        step(3);
        chk("rst_period", int'(period_val), 0);
        chk("rst_high", int'(high_val), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_sig_lost", int'(sig_lost), 0);
        rst = 1'b0;
        step(2);
        en = 1'b1;
        step(2);

        // basic 30/100 waveform at full rate
        repeat (3) pulse(30, 70);

        // prescale 2
        prescale = 8'd2;
        ps = 2;
        do_clear();
        repeat (3) pulse(40, 160);

        // random waveforms and prescales
        for (int b = 0; b < 3; b++) begin
            ps = int'($urandom_range(0, 3));
            prescale = PRESC_W'(ps);
            do_clear();
            repeat (5) pulse(int'($urandom_range(6, 80)), int'($urandom_range(6, 80)));
        end

        // enable dropped mid-high
        prescale = 8'd0;
        ps = 0;
        do_clear();
        repeat (2) pulse(30, 70);
        model_rise(30, 100);
        drive(1'b1, 10);
        en = 1'b0;
        have_start = 0;
        step(5);
        chk("hold_period", int'(period_val), exp_pv);
        chk("hold_high", int'(high_val), exp_hv);
        step(5);
        en = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 70);
        repeat (2) pulse(30, 70);

        // clear coincides with a rise event
        pwm_in = 1'b1;
        step(LAT);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        have_start = 0;
        exp_ovf = 0;
        chk("clr_period", int'(period_val), 0);
        chk("clr_high", int'(high_val), 0);
        chk("clr_ovf", int'(ovf), 0);
        drive(1'b1, 30 - LAT - 1);
        drive(1'b0, 70);
        repeat (2) pulse(30, 70);

        // saturation
        do_clear();
        model_rise(70000, 70070);
        drive(1'b1, 66000);
        chk("sig_lost_sat", int'(sig_lost), 1);
        drive(1'b1, 4000);
        drive(1'b0, 70);
        pulse(30, 70);
        chk("ovf_set", int'(ovf), int'(exp_ovf));
        chk("sig_lost_clr", int'(sig_lost), 0);
        pulse(30, 70);
        chk("ovf_sticky", int'(ovf), int'(exp_ovf));
        do_clear();
        chk("ovf_cleared", int'(ovf), 0);

        // 2-clk low glitch inside a 30-clk high pulse
`ifdef PWM_CAPTURE_FILT_EN
        model_rise(30, 100);
`else
        model_rise(14, 16);
`endif
        drive(1'b1, 14);
        drive(1'b0, 2);
`ifndef PWM_CAPTURE_FILT_EN
        model_rise(14, 84);
`endif
        drive(1'b1, 14);
        drive(1'b0, 70);
        pulse(30, 70);
        pulse(30, 70);

        for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Input-capture counterpart to the PWM counter/generator: measures period and high time of an external PWM waveform.
- Uses the same 2^prescale tick scheme as the generator, so a looped-back generator output reads back its own period and duty settings.
- Sits on the peripheral clock; results go to the register block as read-only capture registers.

Parameters:
- CNT_W, 16, width of the capture counter and result registers.
- PRESC_W, 8, width of the prescale input.

Ports:
- clk  input  1  peripheral clock.
- rst  input  1  asynchronous reset, active-high.
- pwm_in  input  1  external PWM, asynchronous to clk.
- en  input  1  capture enable.
- clear  input  1  synchronous clear of results and flags (single-cycle pulse).
- prescale  input  PRESC_W  tick every 2^prescale clk cycles.
- period_val  output  CNT_W  last complete period, in ticks.
- high_val  output  CNT_W  high time of that same period, in ticks.
- valid  output  1  one-cycle pulse when period_val/high_val update.
- ovf  output  1  sticky: a measurement saturated and was discarded.
- sig_lost  output  1  live: the running counter is currently saturated.

Behaviour:
- Reset (rst=1, async): all registers 0; FSM=IDLE; every output 0.
- Input path: 2-flop synchronizer, then an edge-detect flop.
  - rise_ev/fall_ev asserts 3 clk after a pwm_in transition.
- Prescaler: presc_cnt counts 0..2^prescale-1.
  - tick=1 when presc_cnt==2^prescale-1; presc_cnt then wraps to 0.
  - prescale=0 gives tick every cycle.
  - prescale values larger than CNT_W-1 are clamped to CNT_W-1.
- Counter arithmetic: cnt_inc = cnt + tick, saturating at all-ones.
  - Saturation sets an internal meas_bad flag and drives sig_lost=1.
- FSM states: IDLE, ARM, HIGH, LOW.
  - IDLE: cnt and presc_cnt held at 0. en=1 -> ARM.
  - ARM: waits for the first rise_ev and discards the partial waveform. On rise_ev: cnt<=0, presc_cnt<=0, meas_bad<=0 -> HIGH.
  - HIGH: every cycle cnt<=cnt_inc. On fall_ev: hi_shadow<=cnt_inc, cnt<=cnt_inc -> LOW.
  - LOW: every cycle cnt<=cnt_inc. On rise_ev:
    - If meas_bad=0: period_val<=cnt_inc, high_val<=hi_shadow, valid<=1 on the next cycle (registered, single cycle).
    - If meas_bad=1: no update, no valid, ovf<=1.
    - Then cnt<=0, presc_cnt<=0, meas_bad<=0 -> HIGH.
- Result: with prescale=0, a waveform high H cycles with period P cycles reads high_val=H, period_val=P exactly.
- en=0 in any state -> IDLE next cycle; period_val, high_val and ovf hold.
- clear=1:
  - period_val, high_val, ovf, valid <= 0.
  - FSM -> ARM if en=1, else IDLE.
  - clear has priority over edge events in the same cycle.
- Simultaneous rise_ev and fall_ev cannot occur (single edge-detect path).
- Glitches shorter than one clk may be missed; that is acceptable.
- A prescale change mid-measurement corrupts only that period; software re-arms via clear.
- Results are stable between valid pulses; period_val and high_val always update in the same cycle.

Optional Feature:
- Macro: PWM_CAPTURE_FILT_EN.
- Defined:
  - A 3-sample majority/stability filter follows the synchronizer. The filtered level changes only after 3 consecutive equal synchronized samples.
  - Edge latency becomes 5 clk.
  - Latency is equal on both edges, so measurements are unaffected for pulses of 3 clk or more.
  - Pulses shorter than 3 clk are rejected.
- Undefined: no filter; 3 clk edge latency. The port list is identical in both builds.

Test Plan:
1. prescale=0, en=1, pwm_in high 30 / low 70 clk, repeated 3 times.
   - First rise gives no valid.
   - Each later rise gives valid pulse with period_val=100, high_val=30.
2. prescale=2, pwm_in high 40 / low 160 clk.
   - period_val=50, high_val=10.
   - valid once per 200 clk.
3. prescale=0, pwm_in held high 70000 clk after arming, then normal 100/30 waveform.
   - sig_lost=1 from saturation onward.
   - First closing rise gives no valid, ovf=1.
   - Next period gives valid with period_val=100, high_val=30; ovf stays 1 until a clear pulse.
4. en dropped mid-HIGH for 10 clk, then re-raised.
   - Outputs hold their previous values.
   - The partial period is discarded.
   - The first valid comes only after a full rise-to-rise period.
5. clear pulsed in the same cycle as a rise_ev.
   - Outputs go to 0, no valid, FSM in ARM.
   - Next valid comes two rises later.
6. PWM_CAPTURE_FILT_EN build with a 2-clk glitch low inside a 30-clk high pulse.
   - Reads period_val=100, high_val=30, no spurious valid.
   - The non-filtered build reports the glitch-split values.
